// File: rtl/imem_loader.sv
// imem_loader: parses a length-prefixed byte stream and writes little-endian words into instruction RAM.
// Define IMEM_LOADER_CSUM_EN to require a trailing modulo-256 checksum byte after the data.
module imem_loader #(
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_SIZE   = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] a,
    output logic [31:0]           d,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
`ifdef IMEM_LOADER_CSUM_EN
        CSUM,
`endif
        DONE
    } state_t;
    localparam logic [16:0] MAX_LEN = 17'(MEM_SIZE);
    state_t              state;
    logic [15:0]         len;
    logic [ADDR_WIDTH:0] widx;
    logic [1:0]          bidx;
    logic [23:0]         word;
    logic                acc;
    logic [15:0]         n;
    logic                len_bad;
    logic                last;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]          csum;
`endif
    assign acc     = rx_valid && rx_ready;
    assign n       = {rx_data, len[7:0]};
    assign len_bad = (n == 16'd0) || ({1'b0, n} > MAX_LEN);
    assign last    = 16'(widx) == len - 16'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
            we       <= 1'b0;
            a        <= '0;
            d        <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            len      <= '0;
            widx     <= '0;
            bidx     <= '0;
            word     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum     <= '0;
`endif
        end else begin
            we <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state    <= LEN_LO;
                    rx_ready <= 1'b1;
                    cpu_hold <= 1'b1;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    widx     <= '0;
                    bidx     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                    csum     <= '0;
`endif
                end
                LEN_LO: if (acc) begin
                    len[7:0] <= rx_data;
                    state    <= LEN_HI;
                end
                LEN_HI: if (acc) begin
                    len[15:8] <= rx_data;
                    if (len_bad) begin
                        state    <= DONE;
                        rx_ready <= 1'b0;
                        cpu_hold <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        err      <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (acc) begin
                    bidx <= bidx + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                    csum <= csum + rx_data;
`endif
                    case (bidx)
                        2'd0: word[7:0]   <= rx_data;
                        2'd1: word[15:8]  <= rx_data;
                        2'd2: word[23:16] <= rx_data;
                        default: begin
                            // d is its own register so the next word can start assembling during the write
                            we   <= 1'b1;
                            a    <= widx[ADDR_WIDTH-1:0];
                            d    <= {rx_data, word};
                            widx <= widx + 1'b1;
                            if (last) begin
`ifdef IMEM_LOADER_CSUM_EN
                                state <= CSUM;
`else
                                state    <= DONE;
                                rx_ready <= 1'b0;
                                cpu_hold <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
`endif
                            end
                        end
                    endcase
                end
`ifdef IMEM_LOADER_CSUM_EN
                CSUM: if (acc) begin
                    state    <= DONE;
                    rx_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    err      <= rx_data != csum;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed sessions checked against a stream-level model of expected memory writes.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, we, cpu_hold, busy, done, err;
    logic [6:0]  a;
    logic [31:0] d;
    int          ncmp = 0;
    int          nfail = 0;
    int          cyc = 0;
    bit          exp_err;
    typedef struct {
        logic [6:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    imem_loader #(.ADDR_WIDTH(7), .MEM_SIZE(128)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .we(we), .a(a), .d(d), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (rst_n) chk("cpu_hold_vs_busy", cpu_hold, busy);
        if (we) begin
            if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("wr_a", a, e.a);
                chk("wr_d", d, e.d);
            end
        end
    end

    task automatic model(input logic [7:0] s[$]);
        int n;
        n = int'(s[0]) | (int'(s[1]) << 8);
        exp_err = (n == 0) || (n > 128);
        if (!exp_err)
            for (int k = 0; k < n; k++)
                exp_q.push_back('{7'(k), {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]}});
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        rx_data = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 1, 0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run(input logic [7:0] s_in[$], input int gap, input int adj, input bit mid_start);
        logic [7:0] s[$];
        logic [7:0] sum;
        int c0;
        s = s_in;
        model(s);
`ifdef IMEM_LOADER_CSUM_EN
        if (!exp_err) begin
            sum = 8'h00;
            for (int i = 2; i < s.size(); i++) sum += s[i];
            s.push_back(sum + 8'(adj));
            exp_err = adj != 0;
        end
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_rx_ready", rx_ready, 1);
        c0 = cyc;
        for (int i = 0; i < s.size(); i++) begin
            if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
            if (mid_start && i == 3) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send(s[i]);
        end
        if (gap == 0 && !mid_start) chk("throughput", cyc - c0, s.size());
`ifndef IMEM_LOADER_CSUM_EN
        if (!exp_err) begin
            chk("last_we", we, 1);
            chk("last_busy", busy, 0);
            chk("last_done", done, 1);
        end
`endif
        repeat (2) @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        chk("end_err", err, exp_err);
        chk("end_cpu_hold", cpu_hold, 0);
        chk("end_rx_ready", rx_ready, 0);
        chk("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] s[$];
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_a", a, 0);
        chk("rst_d", d, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run(s, 0, 0, 0);
        chk("normal_hold_a", a, 1);
        chk("normal_hold_d", d, 32'h00100093);
        chk("normal_err", err, 0);

        s = '{8'h00, 8'h00};
        run(s, 0, 0, 0);
        chk("len0_err", err, 1);
        rx_data = 8'h55;
        rx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("done_no_ack", rx_ready, 0);
        end
        rx_valid = 1'b0;

        s = '{8'h81, 8'h00};
        run(s, 0, 0, 0);
        chk("len129_err", err, 1);

        s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run(s, 3, 0, 1);
        chk("bp_a", a, 0);
        chk("bp_d", d, 32'hDEADBEEF);

`ifdef IMEM_LOADER_CSUM_EN
        s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        run(s, 0, 0, 0);
        chk("csum_ok_err", err, 0);
        run(s, 0, 1, 0);
        chk("csum_bad_err", err, 1);
        chk("csum_bad_d", d, 32'h04030201);
        chk("csum_bad_a", a, 0);
`endif

        s = '{8'h80, 8'h00};
        for (int k = 0; k < 128; k++) begin
            s.push_back(8'(k));
            s.push_back(8'h00);
            s.push_back(8'h00);
            s.push_back(8'h00);
        end
        run(s, 0, 0, 0);
        chk("full_a", a, 127);
        chk("full_d", d, 32'h0000007F);
        chk("full_err", err, 0);

        exp_q.push_back('{7'd0, 32'h44332211});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(8'h04);
        send(8'h00);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        rx_data = 8'h66;
        rx_valid = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rx_ready", rx_ready, 0);
        chk("abort_we", we, 0);
        chk("abort_a", a, 0);
        chk("abort_d", d, 0);
        chk("abort_cpu_hold", cpu_hold, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_writes", exp_q.size(), 0);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_busy_after", busy, 0);
        chk("abort_done_after", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
